// File: rtl/simd_dispatch_arbiter.sv
// simd_dispatch_arbiter: dispatches VALU instructions round-robin to SIMD units
// and merges per-unit completion pulses into a single retirement stream.
module simd_dispatch_arbiter #(
    parameter int unsigned NUM_SIMD = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valu_valid,
    output logic                     issue_valu_ready,
    input  logic [5:0]               issue_wfid,
    input  logic [31:0]              issue_opcode,
    input  logic [31:0]              issue_instr_pc,
    input  logic [NUM_SIMD-1:0]      simd_alu_ready,
    output logic [NUM_SIMD-1:0]      simd_alu_select,
    output logic [5:0]               simd_wfid,
    output logic [31:0]              simd_opcode,
    output logic [31:0]              simd_instr_pc,
    input  logic [NUM_SIMD-1:0]      simd_instr_done,
    input  logic [6*NUM_SIMD-1:0]    simd_instr_done_wfid,
    output logic                     sched_instr_done,
    output logic [5:0]               sched_instr_done_wfid,
    output logic                     done_overflow
);

    localparam int unsigned WFID_W = 6;
    localparam int unsigned OP_W   = 32;
    localparam int unsigned PC_W   = 32;
    localparam int unsigned PTR_W  = $clog2(NUM_SIMD);

    typedef struct packed {
        logic [WFID_W-1:0] wfid;
        logic [OP_W-1:0]   opcode;
        logic [PC_W-1:0]   pc;
    } valu_instr_t;

    // First set bit of req at or above ptr, else the lowest set bit overall.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_SIMD-1:0] req,
                                                 input logic [PTR_W-1:0]    ptr);
        logic [PTR_W-1:0] pick_hi;
        logic [PTR_W-1:0] pick_any;
        logic             found_hi;
        pick_hi  = '0;
        pick_any = '0;
        found_hi = 1'b0;
        for (int i = NUM_SIMD - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_any = PTR_W'(i);
                if (PTR_W'(i) >= ptr) begin
                    pick_hi  = PTR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        return found_hi ? pick_hi : pick_any;
    endfunction

    // Pointer advance with wrap at NUM_SIMD-1 (NUM_SIMD need not be a power of two).
    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SIMD - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    logic                    h_valid;
    valu_instr_t             h_instr;
    valu_instr_t             issue_instr;
    valu_instr_t             pay_q;
    logic [PTR_W-1:0]        dptr;
    logic [PTR_W-1:0]        rptr;
    logic [PTR_W-1:0]        dpick;
    logic [PTR_W-1:0]        rpick;
    logic [NUM_SIMD-1:0]     eligible;
    logic [NUM_SIMD-1:0]     pend;
    logic [NUM_SIMD-1:0]     drained;
    logic                    dispatch_now;
    logic                    accept;
    logic                    drain_valid;
    logic [WFID_W-1:0]       wfid_sel;
    logic [WFID_W-1:0]       wreg [NUM_SIMD];

    assign issue_instr   = '{wfid: issue_wfid, opcode: issue_opcode, pc: issue_instr_pc};
    assign simd_wfid     = pay_q.wfid;
    assign simd_opcode   = pay_q.opcode;
    assign simd_instr_pc = pay_q.pc;

    // Dispatch/drain selection; a unit selected last cycle is masked while its ready drops.
    always_comb begin
        eligible         = simd_alu_ready & ~simd_alu_select;
        dispatch_now     = h_valid & (|eligible);
        dpick            = rr_pick(eligible, dptr);
        issue_valu_ready = ~h_valid | dispatch_now;
        accept           = issue_valu_valid & issue_valu_ready;
        drain_valid      = |pend;
        rpick            = rr_pick(pend, rptr);
        drained          = drain_valid ? (NUM_SIMD'(1) << rpick) : '0;
        wfid_sel         = '0;
        for (int i = 0; i < NUM_SIMD; i++) begin
            if (PTR_W'(i) == rpick) begin
                wfid_sel = wreg[i];
            end
        end
    end

    // One-entry holding register between issue and dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_valid <= 1'b0;
            h_instr <= '0;
        end else if (accept) begin
            h_valid <= 1'b1;
            h_instr <= issue_instr;
        end else if (dispatch_now) begin
            h_valid <= 1'b0;
        end
    end

    // Registered one-hot select pulse and payload broadcast.
    always_ff @(posedge clk) begin
        if (rst) begin
            simd_alu_select <= '0;
            pay_q           <= '0;
            dptr            <= '0;
        end else if (dispatch_now) begin
            simd_alu_select <= NUM_SIMD'(1) << dpick;
            pay_q           <= h_instr;
            dptr            <= wrap_inc(dpick);
        end else begin
            simd_alu_select <= '0;
        end
    end

    // Completion capture; a new pulse on an undrained pending unit is an overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend          <= '0;
            done_overflow <= 1'b0;
            for (int i = 0; i < NUM_SIMD; i++) begin
                wreg[i] <= '0;
            end
        end else begin
            pend <= (pend & ~drained) | simd_instr_done;
            if (|(simd_instr_done & pend & ~drained)) begin
                done_overflow <= 1'b1;
            end
            for (int i = 0; i < NUM_SIMD; i++) begin
                if (simd_instr_done[i]) begin
                    wreg[i] <= simd_instr_done_wfid[WFID_W*i +: WFID_W];
                end
            end
        end
    end

    // Round-robin drain, one completion per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sched_instr_done      <= 1'b0;
            sched_instr_done_wfid <= '0;
            rptr                  <= '0;
        end else begin
            sched_instr_done <= drain_valid;
            if (drain_valid) begin
                sched_instr_done_wfid <= wfid_sel;
                rptr                  <= wrap_inc(rpick);
            end
        end
    end

endmodule

// File: tb/tb_simd_dispatch_arbiter.sv
// Testbench for simd_dispatch_arbiter: directed scenarios plus randomized
// traffic, checked against a cycle-level behavioural reference model.
module tb_simd_dispatch_arbiter;

    localparam int N = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valu_valid;
    logic             issue_valu_ready;
    logic [5:0]       issue_wfid;
    logic [31:0]      issue_opcode;
    logic [31:0]      issue_instr_pc;
    logic [N-1:0]     simd_alu_ready;
    logic [N-1:0]     simd_alu_select;
    logic [5:0]       simd_wfid;
    logic [31:0]      simd_opcode;
    logic [31:0]      simd_instr_pc;
    logic [N-1:0]     simd_instr_done;
    logic [6*N-1:0]   simd_instr_done_wfid;
    logic             sched_instr_done;
    logic [5:0]       sched_instr_done_wfid;
    logic             done_overflow;

    int n_vec = 0;
    int n_err = 0;

    simd_dispatch_arbiter #(.NUM_SIMD(N)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .issue_valu_valid      (issue_valu_valid),
        .issue_valu_ready      (issue_valu_ready),
        .issue_wfid            (issue_wfid),
        .issue_opcode          (issue_opcode),
        .issue_instr_pc        (issue_instr_pc),
        .simd_alu_ready        (simd_alu_ready),
        .simd_alu_select       (simd_alu_select),
        .simd_wfid             (simd_wfid),
        .simd_opcode           (simd_opcode),
        .simd_instr_pc         (simd_instr_pc),
        .simd_instr_done       (simd_instr_done),
        .simd_instr_done_wfid  (simd_instr_done_wfid),
        .sched_instr_done      (sched_instr_done),
        .sched_instr_done_wfid (sched_instr_done_wfid),
        .done_overflow         (done_overflow)
    );

    always #5 clk = ~clk;

    // Reference model state: holding slot, last selected unit (-1 = none),
    // broadcast payload, pending completions and their wfids, pointers.
    bit          m_hv;
    logic [5:0]  m_hw;
    logic [31:0] m_ho, m_hp;
    int          m_sel;
    int          m_dptr;
    logic [5:0]  m_pw;
    logic [31:0] m_po, m_pp;
    bit          m_pend [N];
    logic [5:0]  m_w [N];
    int          m_rptr;
    bit          m_done;
    logic [5:0]  m_dw;
    bit          m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hv = 0; m_hw = '0; m_ho = '0; m_hp = '0;
        m_sel = -1; m_dptr = 0;
        m_pw = '0; m_po = '0; m_pp = '0;
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_w[i]    = '0;
        end
        m_rptr = 0; m_done = 0; m_dw = '0; m_ovf = 0;
    endtask

    // One clock: check ready against the model, advance the model, clock, check outputs.
    task automatic cycle();
        int         chosen;
        int         pick;
        bit         exp_rdy;
        logic [N-1:0] exp_sel;
        #1;
        chosen = -1;
        if (m_hv) begin
            for (int k = 0; k < N; k++) begin
                int u;
                u = (m_dptr + k) % N;
                if (chosen < 0 && simd_alu_ready[u] && m_sel != u) chosen = u;
            end
        end
        exp_rdy = !m_hv || (chosen >= 0);
        if (!rst) chk("issue_valu_ready", 64'(issue_valu_ready), 64'(exp_rdy));
        pick = -1;
        for (int k = 0; k < N; k++) begin
            int u;
            u = (m_rptr + k) % N;
            if (pick < 0 && m_pend[u]) pick = u;
        end
        if (rst) begin
            model_reset();
        end else begin
            if (pick >= 0) begin
                m_done = 1; m_dw = m_w[pick]; m_pend[pick] = 0; m_rptr = (pick + 1) % N;
            end else begin
                m_done = 0;
            end
            for (int i = 0; i < N; i++) begin
                if (simd_instr_done[i]) begin
                    if (m_pend[i]) m_ovf = 1;
                    m_pend[i] = 1;
                    m_w[i]    = simd_instr_done_wfid[6*i +: 6];
                end
            end
            if (chosen >= 0) begin
                m_pw = m_hw; m_po = m_ho; m_pp = m_hp;
                m_dptr = (chosen + 1) % N;
            end
            m_sel = chosen;
            if (issue_valu_valid && exp_rdy) begin
                m_hv = 1; m_hw = issue_wfid; m_ho = issue_opcode; m_hp = issue_instr_pc;
            end else if (chosen >= 0) begin
                m_hv = 0;
            end
        end
        @(posedge clk);
        #1;
        exp_sel = '0;
        if (m_sel >= 0) exp_sel[m_sel] = 1'b1;
        chk("simd_alu_select", 64'(simd_alu_select), 64'(exp_sel));
        chk("simd_wfid", 64'(simd_wfid), 64'(m_pw));
        chk("simd_opcode", 64'(simd_opcode), 64'(m_po));
        chk("simd_instr_pc", 64'(simd_instr_pc), 64'(m_pp));
        chk("sched_instr_done", 64'(sched_instr_done), 64'(m_done));
        chk("sched_instr_done_wfid", 64'(sched_instr_done_wfid), 64'(m_dw));
        chk("done_overflow", 64'(done_overflow), 64'(m_ovf));
    endtask

    task automatic set_idle();
        issue_valu_valid     = 1'b0;
        simd_instr_done      = '0;
        simd_instr_done_wfid = '0;
    endtask

    task automatic set_issue(input logic [5:0] w);
        issue_valu_valid = 1'b1;
        issue_wfid       = w;
        issue_opcode     = 32'hA500_0000 | 32'(w);
        issue_instr_pc   = 32'h0000_1000 + 32'(w) * 32'd4;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]   got [$];
        logic [N-1:0] prev_sel;
        int           idx;
        bit           acc;

        model_reset();
        rst = 1'b1;
        issue_wfid = '0; issue_opcode = '0; issue_instr_pc = '0;
        simd_alu_ready = '0;
        set_idle();
        @(posedge clk);
        #1;

        // Reset then idle.
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("reset_ready", 64'(issue_valu_ready), 64'd1);
        chk("reset_select", 64'(simd_alu_select), 64'd0);
        chk("reset_done", 64'(sched_instr_done), 64'd0);
        chk("reset_ovf", 64'(done_overflow), 64'd0);
        cycle();

        // Four back-to-back issues with all units ready.
        simd_alu_ready = 4'b1111;
        set_issue(6'd1); cycle();
        chk("b2b_nosel_yet", 64'(simd_alu_select), 64'd0);
        set_issue(6'd2); cycle();
        chk("b2b_sel0", 64'(simd_alu_select), 64'b0001);
        chk("b2b_wfid0", 64'(simd_wfid), 64'd1);
        set_issue(6'd3); cycle();
        chk("b2b_sel1", 64'(simd_alu_select), 64'b0010);
        chk("b2b_wfid1", 64'(simd_wfid), 64'd2);
        set_issue(6'd4); cycle();
        chk("b2b_sel2", 64'(simd_alu_select), 64'b0100);
        chk("b2b_wfid2", 64'(simd_wfid), 64'd3);
        set_idle(); cycle();
        chk("b2b_sel3", 64'(simd_alu_select), 64'b1000);
        chk("b2b_wfid3", 64'(simd_wfid), 64'd4);
        cycle();
        chk("b2b_drained", 64'(simd_alu_select), 64'd0);

        // Only unit 2 ready: three issues, selects every other cycle, none lost.
        simd_alu_ready = 4'b0100;
        idx = 0;
        prev_sel = '0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) set_issue(6'(20 + idx)); else issue_valu_valid = 1'b0;
            #1;
            acc = issue_valu_valid && issue_valu_ready;
            cycle();
            if (acc) idx++;
            if (simd_alu_select != '0) begin
                chk("u2_sel", 64'(simd_alu_select), 64'b0100);
                chk("u2_spacing", 64'(prev_sel), 64'd0);
                got.push_back(simd_wfid);
            end
            prev_sel = simd_alu_select;
        end
        chk("u2_count", 64'(got.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) chk("u2_order", 64'(got[i]), 64'(20 + i));
        end

        // No unit ready for 5 cycles with H full, then unit 1 comes ready.
        simd_alu_ready = 4'b0000;
        set_issue(6'd33); cycle();
        set_idle();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("stall_ready", 64'(issue_valu_ready), 64'd0);
            cycle();
            chk("stall_select", 64'(simd_alu_select), 64'd0);
        end
        simd_alu_ready = 4'b0010;
        cycle();
        chk("stall_release_sel", 64'(simd_alu_select), 64'b0010);
        chk("stall_release_wfid", 64'(simd_wfid), 64'd33);
        chk("stall_release_op", 64'(simd_opcode), 64'hA500_0021);

        // All four units complete together; drained in index order from rptr=0.
        simd_alu_ready = 4'b1111;
        simd_instr_done = 4'b1111;
        simd_instr_done_wfid = {6'd15, 6'd11, 6'd7, 6'd3};
        cycle();
        chk("done_capture", 64'(sched_instr_done), 64'd0);
        set_idle();
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("done_pulse", 64'(sched_instr_done), 64'd1);
            chk("done_wfid", 64'(sched_instr_done_wfid), 64'(3 + 4 * k));
        end
        cycle();
        chk("done_quiet", 64'(sched_instr_done), 64'd0);

        // Overflow: unit 0 pulses again while it waits behind a drain of unit 3.
        simd_instr_done = 4'b0100;
        simd_instr_done_wfid = {6'd0, 6'd9, 6'd0, 6'd0};
        cycle();
        set_idle(); cycle();
        chk("ovf_pre_wfid", 64'(sched_instr_done_wfid), 64'd9);
        simd_instr_done = 4'b1001;
        simd_instr_done_wfid = {6'd40, 6'd0, 6'd0, 6'd41};
        cycle();
        simd_instr_done = 4'b0001;
        simd_instr_done_wfid = {6'd0, 6'd0, 6'd0, 6'd42};
        cycle();
        chk("ovf_set", 64'(done_overflow), 64'd1);
        chk("ovf_drain3", 64'(sched_instr_done_wfid), 64'd40);
        set_idle(); cycle();
        chk("ovf_drain0", 64'(sched_instr_done_wfid), 64'd42);
        cycle(); cycle();
        chk("ovf_sticky", 64'(done_overflow), 64'd1);

        // Reset mid-operation discards H and pending completions.
        simd_alu_ready = 4'b0000;
        set_issue(6'd50);
        simd_instr_done = 4'b0010;
        simd_instr_done_wfid = {6'd0, 6'd0, 6'd5, 6'd0};
        cycle();
        set_idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rst_ovf", 64'(done_overflow), 64'd0);
        chk("rst_done", 64'(sched_instr_done), 64'd0);
        simd_alu_ready = 4'b1111;
        cycle();
        chk("rst_no_select", 64'(simd_alu_select), 64'd0);
        chk("rst_no_done", 64'(sched_instr_done), 64'd0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            rst                  = ($urandom_range(0, 99) == 0);
            issue_valu_valid     = 1'($urandom_range(0, 1));
            issue_wfid           = 6'($urandom);
            issue_opcode         = $urandom;
            issue_instr_pc       = $urandom;
            simd_alu_ready       = N'($urandom);
            simd_instr_done      = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            simd_instr_done_wfid = (6*N)'($urandom);
            cycle();
        end
        rst = 1'b0;
        set_idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
